// File: rtl/player_motion_ctrl.sv
// Grid-movement controller for the player sprite: tile-paced stepping with a buffered
// turn request, mid-tile reversal, freeze, and wrap-around tunnels at the screen edges.
module player_motion_ctrl #(
    parameter int          TILE_LOG2 = 5,
    parameter int          STEP      = 1,
    parameter int          X_ORIGIN  = 320,
    parameter int          Y_ORIGIN  = 320,
    parameter int          X_MAX     = 639,
    parameter int          Y_MAX     = 479,
    parameter logic [15:0] KEY_LEFT  = 16'h0004,
    parameter logic [15:0] KEY_RIGHT = 16'h0007,
    parameter logic [15:0] KEY_UP    = 16'h001a,
    parameter logic [15:0] KEY_DOWN  = 16'h0016
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 frameTick,
    input  logic                 freeze,
    input  logic [15:0]          keycode,
    input  logic                 openLeft,
    input  logic                 openRight,
    input  logic                 openUp,
    input  logic                 openDown,
    output logic [9-TILE_LOG2:0] tileX,
    output logic [9-TILE_LOG2:0] tileY,
    output logic [9:0]           playerX,
    output logic [9:0]           playerY,
    output logic [1:0]           playerDir,
    output logic                 moving,
    output logic                 reqValid,
    output logic [1:0]           reqDir
);

    typedef enum logic {STOPPED = 1'b0, MOVING = 1'b1} state_t;

    localparam logic [1:0]  DIR_RIGHT  = 2'b00;
    localparam logic [1:0]  DIR_LEFT   = 2'b01;
    localparam logic [1:0]  DIR_UP     = 2'b10;
    localparam logic [1:0]  DIR_DOWN   = 2'b11;
    localparam logic [9:0]  STEP_V     = 10'(STEP);
    localparam logic [10:0] X_LIMIT    = 11'(X_MAX);
    localparam logic [10:0] Y_LIMIT    = 11'(Y_MAX);
    localparam logic [9:0]  X_WRAP     = 10'(X_MAX + 1 - STEP);
    localparam logic [9:0]  Y_WRAP     = 10'(Y_MAX + 1 - STEP);
    localparam logic [9:0]  ALIGN_MASK = 10'((1 << TILE_LOG2) - 1);

    state_t     state_r, nextState_s;
    logic [9:0] posX_r, posY_r, nextX_s, nextY_s;
    logic [1:0] dir_r, nextDir_s, moveDir_s;
    logic [1:0] reqDir_r, nextReqDir_s, keyDir_s;
    logic       reqValid_r, nextReqValid_s;
    logic       keyHit_s, consume_s, step_s, aligned_s, tickEn_s;
    logic [3:0] openVec_s;

    // Right/left and up/down differ only in the low direction bit.
    function automatic logic isOpposite(input logic [1:0] a, input logic [1:0] b);
        return (a[1] == b[1]) && (a[0] != b[0]);
    endfunction

    function automatic logic [9:0] stepAxis(input logic [9:0] pos, input logic fwd,
                                            input logic [10:0] limit, input logic [9:0] wrapTo);
        logic [10:0] sum;
        sum = {1'b0, pos} + {1'b0, STEP_V};
        if (fwd) begin
            if (sum > limit) return 10'd0;
            else             return sum[9:0];
        end else begin
            if (pos < STEP_V) return wrapTo;
            else              return pos - STEP_V;
        end
    endfunction

    assign openVec_s = {openDown, openUp, openLeft, openRight};
    assign aligned_s = ((posX_r & ALIGN_MASK) == 10'd0) && ((posY_r & ALIGN_MASK) == 10'd0);
    assign tickEn_s  = frameTick & ~freeze;

    // Keycode decode into a direction request.
    always_comb begin
        keyHit_s = 1'b1;
        keyDir_s = DIR_RIGHT;
        if (keycode == KEY_RIGHT)     keyDir_s = DIR_RIGHT;
        else if (keycode == KEY_LEFT) keyDir_s = DIR_LEFT;
        else if (keycode == KEY_UP)   keyDir_s = DIR_UP;
        else if (keycode == KEY_DOWN) keyDir_s = DIR_DOWN;
        else                          keyHit_s = 1'b0;
    end

    // Movement FSM: decides whether to step, in which direction, and whether the request is used.
    always_comb begin
        nextState_s = state_r;
        moveDir_s   = dir_r;
        consume_s   = 1'b0;
        step_s      = 1'b0;
        if (tickEn_s) begin
            case (state_r)
                STOPPED: begin
                    if (reqValid_r && openVec_s[reqDir_r]) begin
                        nextState_s = MOVING;
                        moveDir_s   = reqDir_r;
                        consume_s   = 1'b1;
                        step_s      = 1'b1;
                    end else begin
                        nextState_s = STOPPED;
                    end
                end
                MOVING: begin
                    if (reqValid_r && isOpposite(reqDir_r, dir_r)) begin
                        moveDir_s = reqDir_r;
                        consume_s = 1'b1;
                        step_s    = 1'b1;
                    end else if (aligned_s) begin
                        if (reqValid_r && openVec_s[reqDir_r]) begin
                            moveDir_s = reqDir_r;
                            consume_s = 1'b1;
                            step_s    = 1'b1;
                        end else if (openVec_s[dir_r]) begin
                            step_s = 1'b1;
                        end else begin
                            nextState_s = STOPPED;
                        end
                    end else begin
                        step_s = 1'b1;
                    end
                end
                default: nextState_s = STOPPED;
            endcase
        end else begin
            nextState_s = state_r;
        end
    end

    // Position, direction and request next-state.
    always_comb begin
        nextX_s   = posX_r;
        nextY_s   = posY_r;
        nextDir_s = dir_r;
        if (step_s) begin
            nextDir_s = moveDir_s;
            case (moveDir_s)
                DIR_RIGHT: nextX_s = stepAxis(posX_r, 1'b1, X_LIMIT, X_WRAP);
                DIR_LEFT:  nextX_s = stepAxis(posX_r, 1'b0, X_LIMIT, X_WRAP);
                DIR_UP:    nextY_s = stepAxis(posY_r, 1'b0, Y_LIMIT, Y_WRAP);
                DIR_DOWN:  nextY_s = stepAxis(posY_r, 1'b1, Y_LIMIT, Y_WRAP);
                default:   nextX_s = posX_r;
            endcase
        end else begin
            nextDir_s = dir_r;
        end
        // A key seen on the consuming edge replaces the consumed request.
        if (keyHit_s) begin
            nextReqValid_s = 1'b1;
            nextReqDir_s   = keyDir_s;
        end else if (consume_s) begin
            nextReqValid_s = 1'b0;
            nextReqDir_s   = reqDir_r;
        end else begin
            nextReqValid_s = reqValid_r;
            nextReqDir_s   = reqDir_r;
        end
    end

    // State and output registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r    <= STOPPED;
            posX_r     <= 10'(X_ORIGIN);
            posY_r     <= 10'(Y_ORIGIN);
            dir_r      <= DIR_RIGHT;
            reqValid_r <= 1'b0;
            reqDir_r   <= DIR_RIGHT;
        end else begin
            state_r    <= nextState_s;
            posX_r     <= nextX_s;
            posY_r     <= nextY_s;
            dir_r      <= nextDir_s;
            reqValid_r <= nextReqValid_s;
            reqDir_r   <= nextReqDir_s;
        end
    end

    assign playerX   = posX_r;
    assign playerY   = posY_r;
    assign playerDir = dir_r;
    assign moving    = (state_r == MOVING);
    assign reqValid  = reqValid_r;
    assign reqDir    = reqDir_r;
    assign tileX     = posX_r[9:TILE_LOG2];
    assign tileY     = posY_r[9:TILE_LOG2];

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Directed bench for player_motion_ctrl: an arithmetic model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_player_motion_ctrl;

    localparam int TILE = 32;
    localparam int STEP = 1;
    localparam int XO   = 320;
    localparam int YO   = 320;
    localparam int XW   = 640;
    localparam int YW   = 480;

    logic        Clk       = 1'b0;
    logic        Reset     = 1'b0;
    logic        frameTick = 1'b0;
    logic        freeze    = 1'b0;
    logic [15:0] keycode   = 16'h0000;
    logic        openLeft  = 1'b0;
    logic        openRight = 1'b0;
    logic        openUp    = 1'b0;
    logic        openDown  = 1'b0;
    logic [4:0]  tileX, tileY;
    logic [9:0]  playerX, playerY;
    logic [1:0]  playerDir, reqDir;
    logic        moving, reqValid;

    player_motion_ctrl dut (
        .Clk(Clk), .Reset(Reset), .frameTick(frameTick), .freeze(freeze), .keycode(keycode),
        .openLeft(openLeft), .openRight(openRight), .openUp(openUp), .openDown(openDown),
        .tileX(tileX), .tileY(tileY), .playerX(playerX), .playerY(playerY),
        .playerDir(playerDir), .moving(moving), .reqValid(reqValid), .reqDir(reqDir)
    );

    always #5 Clk = ~Clk;

    typedef struct packed { int x; int y; int dir; int mov; int rv; int rd; } mstate_t;
    mstate_t ms;
    int checks   = 0;
    int failures = 0;

    function automatic int dxOf(input int d);
        case (d)
            0:       return 1;
            1:       return -1;
            default: return 0;
        endcase
    endfunction

    function automatic int dyOf(input int d);
        case (d)
            2:       return -1;
            3:       return 1;
            default: return 0;
        endcase
    endfunction

    // Direction vectors summing to zero are opposite; positions wrap modulo the screen size.
    function automatic mstate_t modelNext(input mstate_t s, input bit tick,
                                          input logic [15:0] key, input logic [3:0] opn);
        mstate_t n;
        int go;
        int md;
        n  = s;
        go = 0;
        md = s.dir;
        if (tick) begin
            if (s.mov == 0) begin
                if (s.rv != 0 && opn[s.rd]) begin go = 1; md = s.rd; n.rv = 0; n.mov = 1; end
            end else if (s.rv != 0 && s.rd != s.dir && dxOf(s.rd) + dxOf(s.dir) == 0
                         && dyOf(s.rd) + dyOf(s.dir) == 0) begin
                go = 1; md = s.rd; n.rv = 0;
            end else if (s.x % TILE == 0 && s.y % TILE == 0) begin
                if (s.rv != 0 && opn[s.rd]) begin go = 1; md = s.rd; n.rv = 0; end
                else if (opn[s.dir])        go = 1;
                else                        n.mov = 0;
            end else begin
                go = 1;
            end
        end
        if (go != 0) begin
            n.dir = md;
            n.x   = (s.x + dxOf(md) * STEP + XW) % XW;
            n.y   = (s.y + dyOf(md) * STEP + YW) % YW;
        end
        if (key == 16'h0007)      begin n.rv = 1; n.rd = 0; end
        else if (key == 16'h0004) begin n.rv = 1; n.rd = 1; end
        else if (key == 16'h001a) begin n.rv = 1; n.rd = 2; end
        else if (key == 16'h0016) begin n.rv = 1; n.rd = 3; end
        return n;
    endfunction

    always @(posedge Clk or posedge Reset) begin
        if (Reset) ms <= '{x: XO, y: YO, dir: 0, mov: 0, rv: 0, rd: 0};
        else       ms <= modelNext(ms, frameTick && !freeze, keycode,
                                   {openDown, openUp, openLeft, openRight});
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compareAll();
        chk("playerX",   int'(playerX),   ms.x);
        chk("playerY",   int'(playerY),   ms.y);
        chk("tileX",     int'(tileX),     ms.x / TILE);
        chk("tileY",     int'(tileY),     ms.y / TILE);
        chk("playerDir", int'(playerDir), ms.dir);
        chk("moving",    int'(moving),    ms.mov);
        chk("reqValid",  int'(reqValid),  ms.rv);
        chk("reqDir",    int'(reqDir),    ms.rd);
    endtask

    task automatic cyc();
        @(negedge Clk);
        compareAll();
    endtask

    task automatic doTicks(input int n);
        for (int i = 0; i < n; i++) begin
            frameTick = 1'b1;
            cyc();
            frameTick = 1'b0;
            cyc();
        end
    endtask

    task automatic resetPulse();
        Reset = 1'b1;
        cyc();
        Reset = 1'b0;
        cyc();
    endtask

    initial begin
        #2 Reset = 1'b1;
        cyc();
        cyc();
        chk("rst_X", int'(playerX), 320);
        chk("rst_Y", int'(playerY), 320);
        chk("rst_tileX", int'(tileX), 10);
        chk("rst_dir", int'(playerDir), 0);
        chk("rst_moving", int'(moving), 0);
        chk("rst_reqValid", int'(reqValid), 0);
        Reset = 1'b0;
        cyc();

        // Straight run to the next tile, then a wall stops it.
        keycode = 16'h0007; openRight = 1'b1;
        cyc();
        doTicks(32);
        chk("run_X", int'(playerX), 352);
        chk("run_moving", int'(moving), 1);
        openRight = 1'b0;
        doTicks(1);
        chk("wall_X", int'(playerX), 352);
        chk("wall_moving", int'(moving), 0);
        doTicks(1);
        chk("hold_X", int'(playerX), 352);
        chk("hold_reqValid", int'(reqValid), 1);

        // Asynchronous reset in the middle of a move.
        openRight = 1'b1;
        doTicks(1);
        chk("premid_X", int'(playerX), 353);
        #1 Reset = 1'b1;
        #1;
        chk("midrst_X", int'(playerX), 320);
        chk("midrst_Y", int'(playerY), 320);
        chk("midrst_dir", int'(playerDir), 0);
        chk("midrst_moving", int'(moving), 0);
        chk("midrst_reqValid", int'(reqValid), 0);
        cyc();
        Reset = 1'b0;
        cyc();

        // Buffered turn taken at the next tile boundary.
        doTicks(10);
        chk("buf_X330", int'(playerX), 330);
        keycode = 16'h001a;
        cyc();
        keycode = 16'h0000; openUp = 1'b1;
        doTicks(22);
        chk("buf_X352", int'(playerX), 352);
        chk("buf_reqValid", int'(reqValid), 1);
        doTicks(1);
        chk("turn_Y", int'(playerY), 319);
        chk("turn_dir", int'(playerDir), 2);
        chk("turn_reqValid", int'(reqValid), 0);

        // Mid-tile reversal.
        keycode = 16'h0007; openUp = 1'b0;
        resetPulse();
        doTicks(10);
        keycode = 16'h0004;
        cyc();
        doTicks(1);
        chk("rev_X", int'(playerX), 329);
        chk("rev_dir", int'(playerDir), 1);
        chk("rev_moving", int'(moving), 1);

        // Right-edge tunnel.
        keycode = 16'h0007;
        resetPulse();
        doTicks(288);
        chk("wrap_X608", int'(playerX), 608);
        doTicks(31);
        chk("wrap_X639", int'(playerX), 639);
        doTicks(1);
        chk("wrap_X0", int'(playerX), 0);

        // Freeze blocks movement but not request latching.
        keycode = 16'h0016; freeze = 1'b1;
        doTicks(10);
        chk("frz_X", int'(playerX), 0);
        chk("frz_Y", int'(playerY), 320);
        chk("frz_reqValid", int'(reqValid), 1);
        chk("frz_reqDir", int'(reqDir), 3);
        freeze = 1'b0; openDown = 1'b1;
        doTicks(1);
        chk("unfrz_Y", int'(playerY), 321);
        chk("unfrz_dir", int'(playerDir), 3);

        // Left-edge tunnel.
        keycode = 16'h0004; openLeft = 1'b1; openDown = 1'b0; openRight = 1'b0;
        resetPulse();
        doTicks(320);
        chk("lwrap_X0", int'(playerX), 0);
        doTicks(1);
        chk("lwrap_X639", int'(playerX), 639);
        chk("lwrap_dir", int'(playerDir), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
